// File: rtl/pmem_init_ram.sv
`default_nettype none
// ============================================================================
// Module   : pmem_init_ram
// Purpose  : Parametrised single-port instruction/data memory with a power-up
//            fill sequencer. Reset does not clear the array; instead the
//            sequencer writes one fill word per clock after reset releases
//            (or after a reinit request). Optional registered read port and
//            a sticky error flag for writes attempted while not ready.
// Ports    : clk      - clock, rising edge
//            rst      - asynchronous reset, active-high
//            reinit   - sync pulse, restart the fill (ignored while filling)
//            addr     - access address
//            we       - write enable
//            datain   - write data
//            dataout  - read data (0 while filling)
//            ready    - 1 once the fill is complete
//            busy_err - sticky, set by we = 1 while not ready
//            err_clr  - sync pulse, clears busy_err (a same-edge set wins)
// Revision : 1.0 - initial release
// ============================================================================
module pmem_init_ram #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 8,
  parameter int                 INIT_MODE = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL  = '0,
  parameter int                 READ_LAT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reinit,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              ready,
  output logic              busy_err,
  input  logic              err_clr
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  // One bit wider than the address so "all words written" is unambiguous.
  localparam logic [ADDR_W:0]   LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   ptr_nxt;
  logic [DATA_W-1:0] fill_data;
  logic [DATA_W-1:0] mem [DEPTH];

  // --------------------------------------------------------------------------
  // Fill sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_INIT: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST_PTR) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (reinit) begin
          state_nxt = ST_INIT;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        ptr_nxt   = '0;
      end
    endcase
  end

  assign ready = (state == ST_READY);

  // --------------------------------------------------------------------------
  // Fill pattern
  // --------------------------------------------------------------------------
  generate
    if (INIT_MODE == 1) begin : g_fill_addr
      if (ADDR_W >= DATA_W) begin : g_trunc
        assign fill_data = ptr[DATA_W-1:0];
      end else begin : g_zext
        assign fill_data = {{(DATA_W - ADDR_W){1'b0}}, ptr[ADDR_W-1:0]};
      end
    end else if (INIT_MODE == 2) begin : g_fill_const
      assign fill_data = INIT_VAL;
    end else begin : g_fill_zero
      assign fill_data = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage. No reset: contents survive rst and are rewritten by the fill.
  // While rst is held the sequencer sits at word 0, which is the first word
  // refilled after release anyway, so those writes are never observable.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[ptr[ADDR_W-1:0]] <= fill_data;
    end else if (we) begin
      mem[addr] <= datain;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error: a set on the same edge as err_clr takes priority.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_err <= 1'b0;
    end else if (we && (state == ST_INIT)) begin
      busy_err <= 1'b1;
    end else if (err_clr) begin
      busy_err <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
  generate
    if (READ_LAT == 0) begin : g_comb_read
      assign dataout = (state == ST_READY) ? mem[addr] : '0;
    end else begin : g_reg_read
      logic [DATA_W-1:0] rd_q;

      // Write-first: a write on the same edge returns the new data.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_q <= '0;
        end else if (state == ST_READY) begin
          rd_q <= we ? datain : mem[addr];
        end else begin
          rd_q <= '0;
        end
      end

      // Masked so the output is 0 from the first cycle of a reinit fill.
      assign dataout = (state == ST_READY) ? rd_q : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pmem_init_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_init_ram
// Purpose  : Self-checking bench for pmem_init_ram. Two instances share the
//            stimulus: inst 0 (INIT_MODE 1, combinational read) and inst 1
//            (INIT_MODE 2 / INIT_VAL 0x00C3, registered read), DATA_W 16,
//            ADDR_W 4. A behavioural model predicts every output each cycle;
//            literal checks pin the model at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_init_ram;

  logic        clk;
  logic        rst;
  logic        reinit;
  logic [3:0]  addr;
  logic        we;
  logic [15:0] datain;
  logic        err_clr;

  logic [15:0] dout0, dout1;
  logic        rdy0, rdy1;
  logic        berr0, berr1;

  int total = 0;
  int bad   = 0;

  pmem_init_ram #(
    .DATA_W(16), .ADDR_W(4), .INIT_MODE(1), .INIT_VAL(16'h0000), .READ_LAT(0)
  ) dut0 (
    .clk(clk), .rst(rst), .reinit(reinit), .addr(addr), .we(we),
    .datain(datain), .dataout(dout0), .ready(rdy0), .busy_err(berr0),
    .err_clr(err_clr)
  );

  pmem_init_ram #(
    .DATA_W(16), .ADDR_W(4), .INIT_MODE(2), .INIT_VAL(16'h00C3), .READ_LAT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .reinit(reinit), .addr(addr), .we(we),
    .datain(datain), .dataout(dout1), .ready(rdy1), .busy_err(berr1),
    .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------------------
  // Behavioural model: fill counts down the words still to be written.
  // --------------------------------------------------------------------------
  logic [15:0] m_mem [2][16];
  int          m_left;
  logic        m_busy;
  logic [15:0] m_rd;

  function automatic logic [15:0] pat(int k, int idx);
    return (k == 0) ? 16'(idx) : 16'h00C3;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) m_mem[k][i] = 16'h0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 16;
      m_busy = 1'b0;
      m_rd   = 16'h0;
    end else if (m_left != 0) begin
      for (int k = 0; k < 2; k++) m_mem[k][16 - m_left] = pat(k, 16 - m_left);
      m_left = m_left - 1;
      if (we) m_busy = 1'b1;
      else if (err_clr) m_busy = 1'b0;
      m_rd = 16'h0;
    end else begin
      m_rd = we ? datain : m_mem[1][addr];
      if (we) begin
        m_mem[0][addr] = datain;
        m_mem[1][addr] = datain;
      end
      if (err_clr) m_busy = 1'b0;
      if (reinit) m_left = 16;
    end
  end

  task automatic cmp(string nm, logic [15:0] got, logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  // Per-cycle compare against the model, 2 time units after each negedge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      cmp("m_ready0", {15'b0, rdy0},  {15'b0, m_left == 0});
      cmp("m_ready1", {15'b0, rdy1},  {15'b0, m_left == 0});
      cmp("m_berr0",  {15'b0, berr0}, {15'b0, m_busy});
      cmp("m_berr1",  {15'b0, berr1}, {15'b0, m_busy});
      cmp("m_dout0",  dout0, (m_left == 0) ? m_mem[0][addr] : 16'h0);
      cmp("m_dout1",  dout1, (m_left == 0) ? m_rd : 16'h0);
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus. Inputs change 3 units after a negedge.
  // --------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy0 && n < 40) begin
      step();
      n++;
    end
    if (!rdy0) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=%0b want 1 within 40 cycles", rdy0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; reinit = 1'b0; addr = '0; we = 1'b0; datain = '0; err_clr = 1'b0;
    step();
    cmp("rst_ready", {15'b0, rdy0}, 16'h0);
    cmp("rst_dout1", dout1, 16'h0);
    step();

    // Fill after reset: exactly 16 cycles.
    rst = 1'b0;
    wait_ready(n);
    cmp("fill_len", 16'(n), 16'd16);

    // INIT_MODE 1 pattern.
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      step();
      cmp("mode1_word", dout0, 16'(a));
    end

    // Write then read next cycle.
    addr = 4'h3; we = 1'b1; datain = 16'hBEEF;
    step();
    we = 1'b0;
    cmp("wr_rd_comb", dout0, 16'hBEEF);
    cmp("wr_first_reg", dout1, 16'hBEEF);
    addr = 4'h4;
    #1;
    cmp("comb_follow", dout0, 16'h0004);
    cmp("reg_latency", dout1, 16'hBEEF);
    step();
    cmp("reg_read4", dout1, 16'h00C3);

    // Same-edge write/read.
    addr = 4'h3; we = 1'b1; datain = 16'h1234;
    step();
    we = 1'b0;
    cmp("same_edge_reg", dout1, 16'h1234);
    cmp("same_edge_comb", dout0, 16'h1234);

    // Writes during INIT are dropped and flag busy_err; set beats clear.
    reinit = 1'b1;
    step();
    reinit = 1'b0;
    cmp("reinit_ready_low", {15'b0, rdy0}, 16'h0);
    addr = 4'h5; we = 1'b1; datain = 16'hAAAA; err_clr = 1'b1;
    step();
    we = 1'b0; err_clr = 1'b0;
    cmp("busy_set_wins", {15'b0, berr0}, 16'h1);
    wait_ready(n);
    addr = 4'h5;
    #1;
    cmp("dropped_write", dout0, 16'h0005);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    cmp("busy_clear", {15'b0, berr0}, 16'h0);

    // Fill all with 0xFFFF, reinit (with a write on the reinit edge).
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a); we = 1'b1; datain = 16'hFFFF;
      step();
    end
    addr = 4'h7; datain = 16'h1111; reinit = 1'b1;
    step();
    we = 1'b0; reinit = 1'b0;
    wait_ready(n);
    cmp("reinit_len", 16'(n), 16'd16);
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      step();
    end
    addr = 4'hA;
    step();
    cmp("const_fill", dout1, 16'h00C3);
    cmp("addr_fill", dout0, 16'h000A);
    addr = 4'h7;
    step();
    cmp("reinit_wr_overwritten", dout1, 16'h00C3);

    // Reset in the middle of a fill restarts it from word 0.
    reinit = 1'b1;
    step();
    reinit = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(n);
    cmp("rst_midfill_len", 16'(n), 16'd16);
    addr = 4'hF;
    #1;
    cmp("rst_midfill_word", dout0, 16'h000F);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
